// File: rtl/tl_ul_responder.sv
// tl_ul_responder: TileLink-UL memory responder with one outstanding request,
// fixed response latency and byte-masked 64-bit storage.
module tl_ul_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        a_valid_i,
  output logic        a_ready_o,
  input  logic [2:0]  a_opcode_i,
  input  logic [2:0]  a_param_i,
  input  logic [2:0]  a_size_i,
  input  logic [8:0]  a_source_i,
  input  logic [31:0] a_address_i,
  input  logic [7:0]  a_mask_i,
  input  logic [63:0] a_data_i,
  output logic        d_valid_o,
  input  logic        d_ready_i,
  output logic [2:0]  d_opcode_o,
  output logic [1:0]  d_param_o,
  output logic [2:0]  d_size_o,
  output logic [8:0]  d_source_o,
  output logic        d_denied_o,
  output logic [63:0] d_data_o,
  output logic        d_corrupt_o,
  output logic        err_seen_o
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd8;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        ready_q, err_q;
  logic [2:0]  d_opcode_q, d_size_q;
  logic [8:0]  d_source_q;
  logic        d_denied_q, d_corrupt_q;
  logic [63:0] d_data_q;
  logic [63:0] mem_q [DEPTH_WORDS];
  logic        accept, is_get, is_put, ack_data, denied, unused_bits;
  logic [31:0] off;
  logic [AW-1:0] idx;
  logic [2:0]  lsb_mask;
  assign accept   = a_valid_i && ready_q;
  assign is_get   = a_opcode_i == 3'd4;
  assign is_put   = a_opcode_i == 3'd0 || a_opcode_i == 3'd1;
  assign ack_data = a_opcode_i == 3'd2 || a_opcode_i == 3'd3 || is_get;
  assign off      = a_address_i - BASE_ADDR;
  assign idx      = off[AW+2:3];
  assign lsb_mask = 3'((4'd1 << a_size_i[1:0]) - 4'd1);
  assign denied   = !(is_get || is_put) || a_address_i < BASE_ADDR ||
                    {1'b0, a_address_i} >= LIMIT || a_size_i > 3'd3 ||
                    (a_address_i[2:0] & lsb_mask) != 3'd0;
  assign unused_bits = ^{a_param_i, off};
  assign a_ready_o   = ready_q;
  assign d_valid_o   = state_q == RESP;
  assign d_opcode_o  = d_opcode_q;
  assign d_param_o   = 2'd0;
  assign d_size_o    = d_size_q;
  assign d_source_o  = d_source_q;
  assign d_denied_o  = d_denied_q;
  assign d_data_o    = d_data_q;
  assign d_corrupt_o = d_corrupt_q;
  assign err_seen_o  = err_q;
  always_ff @(posedge clk_i)
    if (accept && is_put && !denied)
      for (int b = 0; b < 8; b++)
        if (a_mask_i[b]) mem_q[idx][8*b +: 8] <= a_data_i[8*b +: 8];
  // a_ready is a flop so it stays low through reset and rises one clock after release
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      d_opcode_q  <= 3'd0;
      d_size_q    <= 3'd0;
      d_source_q  <= 9'd0;
      d_denied_q  <= 1'b0;
      d_data_q    <= 64'd0;
      d_corrupt_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE:
          if (accept) begin
            state_q     <= (LATENCY == 0) ? RESP : WAIT;
            cnt_q       <= 4'((LATENCY == 0) ? 0 : LATENCY - 1);
            ready_q     <= 1'b0;
            err_q       <= err_q | denied;
            d_opcode_q  <= ack_data ? 3'd1 : 3'd0;
            d_size_q    <= a_size_i;
            d_source_q  <= a_source_i;
            d_denied_q  <= denied;
            d_data_q    <= (is_get && !denied) ? mem_q[idx] : 64'd0;
            d_corrupt_q <= denied && ack_data;
          end else ready_q <= 1'b1;
        WAIT: begin
          cnt_q <= (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
          if (cnt_q == 4'd0) state_q <= RESP;
        end
        RESP:
          if (d_ready_i) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_tl_ul_responder.sv
// tb_tl_ul_responder: vector table plus scoreboard for tl_ul_responder, with
// stall, reset-in-flight and zero-latency sequences.
module tb_tl_ul_responder;
  typedef struct {
    logic [2:0] op, size; logic [8:0] src; logic [31:0] addr; logic [7:0] mask;
    logic [63:0] data; logic [2:0] eop; logic eden, ecor; logic [63:0] edata;
  } vec_t;
  typedef struct {
    logic [2:0] op, size; logic [8:0] src; logic den, cor, err;
    logic [63:0] data; int acc; bit lat;
  } exp_t;
  logic clk, rst;
  logic a_valid, a_ready, d_valid, d_ready, d_denied, d_corrupt, err_seen;
  logic [2:0] a_opcode, a_param, a_size, d_opcode, d_size;
  logic [8:0] a_source, d_source;
  logic [31:0] a_address;
  logic [7:0] a_mask;
  logic [63:0] a_data, d_data;
  logic [1:0] d_param;
  logic z_a_valid, z_a_ready, z_d_valid, z_d_denied, z_d_corrupt, z_err_seen;
  logic [2:0] z_a_opcode, z_d_opcode, z_d_size;
  logic [8:0] z_d_source;
  logic [63:0] z_d_data;
  logic [1:0] z_d_param;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  logic err_exp = 1'b0;
  exp_t sb[$];
  vec_t tbl[20];

  tl_ul_responder u0 (
    .clk_i(clk), .rst_i(rst), .a_valid_i(a_valid), .a_ready_o(a_ready),
    .a_opcode_i(a_opcode), .a_param_i(a_param), .a_size_i(a_size),
    .a_source_i(a_source), .a_address_i(a_address), .a_mask_i(a_mask),
    .a_data_i(a_data), .d_valid_o(d_valid), .d_ready_i(d_ready),
    .d_opcode_o(d_opcode), .d_param_o(d_param), .d_size_o(d_size),
    .d_source_o(d_source), .d_denied_o(d_denied), .d_data_o(d_data),
    .d_corrupt_o(d_corrupt), .err_seen_o(err_seen));

  tl_ul_responder #(.LATENCY(0)) u1 (
    .clk_i(clk), .rst_i(rst), .a_valid_i(z_a_valid), .a_ready_o(z_a_ready),
    .a_opcode_i(z_a_opcode), .a_param_i(3'd0), .a_size_i(3'd3),
    .a_source_i(9'h055), .a_address_i(32'h8000_0008), .a_mask_i(8'hFF),
    .a_data_i(64'hA5A5_0F0F_1234_5678), .d_valid_o(z_d_valid), .d_ready_i(1'b1),
    .d_opcode_o(z_d_opcode), .d_param_o(z_d_param), .d_size_o(z_d_size),
    .d_source_o(z_d_source), .d_denied_o(z_d_denied), .d_data_o(z_d_data),
    .d_corrupt_o(z_d_corrupt), .err_seen_o(z_err_seen));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  always @(negedge clk)
    if (!rst && d_valid && d_ready) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_resp: got source %h expected no response", d_source);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("d_opcode", 64'(d_opcode), 64'(e.op));
        chk("d_size", 64'(d_size), 64'(e.size));
        chk("d_source", 64'(d_source), 64'(e.src));
        chk("d_denied", 64'(d_denied), 64'(e.den));
        chk("d_corrupt", 64'(d_corrupt), 64'(e.cor));
        chk("d_data", d_data, e.data);
        chk("err_seen", 64'(err_seen), 64'(e.err));
        if (e.lat) chk("latency", 64'(cyc - e.acc), 64'd3);
      end
    end

  task automatic send(input vec_t v, input bit lat);
    exp_t e;
    @(posedge clk); #1;
    a_opcode = v.op; a_size = v.size; a_source = v.src; a_address = v.addr;
    a_mask = v.mask; a_data = v.data; a_param = 3'd5; a_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (a_ready) begin
        err_exp = err_exp | v.eden;
        e = '{v.eop, v.size, v.src, v.eden, v.ecor, err_exp, v.edata, cyc, lat};
        sb.push_back(e);
        @(posedge clk); #1 a_valid = 1'b0;
        return;
      end
    end
    chk("accept_timeout", 64'd0, 64'd1);
    a_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && sb.size() != 0; t++) @(negedge clk);
    chk("drain_left", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    vec_t v;
    int za[3], zr[3], n, m;
    logic [63:0] zd[3];
    logic acc;
    tbl[0]  = '{3'd0, 3'd3, 9'h1A5, 32'h8000_0010, 8'hFF, 64'h1122334455667788, 3'd0, 1'b0, 1'b0, 64'd0};
    tbl[1]  = '{3'd4, 3'd3, 9'h011, 32'h8000_0010, 8'hFF, 64'd0, 3'd1, 1'b0, 1'b0, 64'h1122334455667788};
    tbl[2]  = '{3'd1, 3'd3, 9'h022, 32'h8000_0010, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 3'd0, 1'b0, 1'b0, 64'd0};
    tbl[3]  = '{3'd4, 3'd3, 9'h033, 32'h8000_0010, 8'hFF, 64'd0, 3'd1, 1'b0, 1'b0, 64'h11223344_BBBBBBBB};
    tbl[4]  = '{3'd1, 3'd2, 9'h044, 32'h8000_0014, 8'hF0, 64'hCAFEF00D_00000000, 3'd0, 1'b0, 1'b0, 64'd0};
    tbl[5]  = '{3'd4, 3'd1, 9'h055, 32'h8000_0012, 8'h03, 64'd0, 3'd1, 1'b0, 1'b0, 64'hCAFEF00D_BBBBBBBB};
    tbl[6]  = '{3'd0, 3'd3, 9'h066, 32'h8000_07F8, 8'hFF, 64'h0123456789ABCDEF, 3'd0, 1'b0, 1'b0, 64'd0};
    tbl[7]  = '{3'd4, 3'd3, 9'h077, 32'h8000_07F8, 8'hFF, 64'd0, 3'd1, 1'b0, 1'b0, 64'h0123456789ABCDEF};
    tbl[8]  = '{3'd4, 3'd3, 9'h088, 32'h7FFF_FFF8, 8'hFF, 64'd0, 3'd1, 1'b1, 1'b1, 64'd0};
    tbl[9]  = '{3'd4, 3'd3, 9'h099, 32'h8000_0804, 8'hFF, 64'd0, 3'd1, 1'b1, 1'b1, 64'd0};
    tbl[10] = '{3'd0, 3'd3, 9'h0AA, 32'h7FFF_FFF8, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 3'd0, 1'b1, 1'b0, 64'd0};
    tbl[11] = '{3'd4, 3'd3, 9'h0BB, 32'h8000_07F8, 8'hFF, 64'd0, 3'd1, 1'b0, 1'b0, 64'h0123456789ABCDEF};
    tbl[12] = '{3'd4, 3'd2, 9'h0CC, 32'h8000_0002, 8'hFF, 64'd0, 3'd1, 1'b1, 1'b1, 64'd0};
    tbl[13] = '{3'd4, 3'd4, 9'h0DD, 32'h8000_0020, 8'hFF, 64'd0, 3'd1, 1'b1, 1'b1, 64'd0};
    tbl[14] = '{3'd2, 3'd3, 9'h0EE, 32'h8000_0010, 8'hFF, 64'd5, 3'd1, 1'b1, 1'b1, 64'd0};
    tbl[15] = '{3'd3, 3'd3, 9'h0FF, 32'h8000_0010, 8'hFF, 64'd5, 3'd1, 1'b1, 1'b1, 64'd0};
    tbl[16] = '{3'd5, 3'd3, 9'h100, 32'h8000_0010, 8'hFF, 64'd5, 3'd0, 1'b1, 1'b0, 64'd0};
    tbl[17] = '{3'd7, 3'd3, 9'h1FF, 32'h8000_0010, 8'hFF, 64'd5, 3'd0, 1'b1, 1'b0, 64'd0};
    tbl[18] = '{3'd4, 3'd3, 9'h101, 32'h8000_0800, 8'hFF, 64'd0, 3'd1, 1'b1, 1'b1, 64'd0};
    tbl[19] = '{3'd4, 3'd3, 9'h102, 32'h8000_0010, 8'hFF, 64'd0, 3'd1, 1'b0, 1'b0, 64'hCAFEF00D_BBBBBBBB};
    a_valid = 0; a_opcode = 0; a_param = 0; a_size = 0; a_source = 0; a_address = 0;
    a_mask = 0; a_data = 0; d_ready = 1; z_a_valid = 0; z_a_opcode = 0;
    rst = 0;
    #1 rst = 1;
    #2;
    chk("rst_d_valid", 64'(d_valid), 64'd0);
    chk("rst_d_data", d_data, 64'd0);
    chk("rst_d_opcode", 64'(d_opcode), 64'd0);
    chk("rst_err_seen", 64'(err_seen), 64'd0);
    repeat (2) @(negedge clk);
    chk("rst_a_ready", 64'(a_ready), 64'd0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rel_a_ready_pre", 64'(a_ready), 64'd0);
    @(negedge clk);
    chk("rel_a_ready_post", 64'(a_ready), 64'd1);

    for (int i = 0; i < 20; i++) send(tbl[i], 1'b1);
    drain();

    // hold the response for five RESP cycles, then release it
    d_ready = 0;
    v = '{3'd4, 3'd3, 9'h123, 32'h8000_0010, 8'hFF, 64'd0, 3'd1, 1'b0, 1'b0, 64'hCAFEF00D_BBBBBBBB};
    send(v, 1'b0);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (d_valid) break;
    end
    for (int i = 0; i < 5; i++) begin
      chk("stall_d_valid", 64'(d_valid), 64'd1);
      chk("stall_d_opcode", 64'(d_opcode), 64'd1);
      chk("stall_d_source", 64'(d_source), 64'h123);
      chk("stall_d_data", d_data, 64'hCAFEF00D_BBBBBBBB);
      chk("stall_a_ready", 64'(a_ready), 64'd0);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #1 d_ready = 1;
    @(negedge clk);
    chk("hs_a_ready", 64'(a_ready), 64'd0);
    @(negedge clk);
    chk("after_hs_a_ready", 64'(a_ready), 64'd1);
    drain();

    // reset while the request sits in WAIT
    v = '{3'd4, 3'd3, 9'h0AB, 32'h8000_0010, 8'hFF, 64'd0, 3'd1, 1'b0, 1'b0, 64'hCAFEF00D_BBBBBBBB};
    send(v, 1'b0);
    #2 rst = 1;
    #1;
    chk("wait_rst_d_valid", 64'(d_valid), 64'd0);
    chk("wait_rst_err_seen", 64'(err_seen), 64'd0);
    chk("wait_rst_a_ready", 64'(a_ready), 64'd0);
    void'(sb.pop_back());
    err_exp = 1'b0;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("wait_rel_a_ready_pre", 64'(a_ready), 64'd0);
    @(negedge clk);
    chk("wait_rel_a_ready_post", 64'(a_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_stale_resp", 64'(d_valid), 64'd0);
    end
    send(v, 1'b1);
    drain();

    // zero-latency instance: Put then two Gets held back-to-back
    n = 0; m = 0;
    za = '{0, 0, 0}; zr = '{0, 0, 0}; zd = '{64'd0, 64'd0, 64'd0};
    @(posedge clk); #1 z_a_opcode = 3'd0; z_a_valid = 1;
    for (int t = 0; t < 20 && m < 3; t++) begin
      @(negedge clk);
      acc = z_a_valid && z_a_ready;
      if (z_d_valid && m < 3) begin zr[m] = cyc; zd[m] = z_d_data; m++; end
      if (acc) begin za[n] = cyc; n++; end
      @(posedge clk); #1;
      if (acc) begin
        z_a_opcode = 3'd4;
        if (n >= 3) z_a_valid = 0;
      end
    end
    z_a_valid = 0;
    chk("z_accepts", 64'(n), 64'd3);
    chk("z_resps", 64'(m), 64'd3);
    for (int i = 0; i < 3; i++) chk("z_latency", 64'(zr[i] - za[i]), 64'd1);
    for (int i = 0; i < 2; i++) chk("z_spacing", 64'(za[i+1] - za[i]), 64'd2);
    chk("z_put_data", zd[0], 64'd0);
    chk("z_get1_data", zd[1], 64'hA5A5_0F0F_1234_5678);
    chk("z_get2_data", zd[2], 64'hA5A5_0F0F_1234_5678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tl_ul_responder.md
TL_UL_RESPONDER -- requirements
Module: tl_ul_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h8000_0000, meaning the first byte address served.
REQ-002 SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 64-bit storage words (power of 2).
REQ-003 SHALL have parameter LATENCY, default 2, range 0..15, meaning the extra wait cycles before a response.
REQ-004 SHALL have one clock and an asynchronous, active-high reset, as follows:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
REQ-005 SHALL have these A-channel ports:
- a_valid  in  1  request valid
- a_ready  out  1  request accepted
- a_opcode  in  3  TileLink A opcode
- a_param  in  3  ignored
- a_size  in  3  log2 of transfer bytes
- a_source  in  9  requester tag
- a_address  in  32  byte address
- a_mask  in  8  byte lanes
- a_data  in  64  write data
REQ-006 SHALL have these D-channel ports:
- d_valid  out  1  response valid
- d_ready  in  1  response taken
- d_opcode  out  3  TileLink D opcode
- d_param  out  2  always 0
- d_size  out  3  echoed a_size
- d_source  out  9  echoed a_source
- d_denied  out  1  request refused
- d_data  out  64  read data
- d_corrupt  out  1  data invalid
REQ-007 SHALL have port err_seen  out  1, a sticky flag set on any denied request.

Function
REQ-008 SHALL implement a three-state machine: IDLE, WAIT, RESP.
REQ-009 SHALL assert a_ready only in IDLE, so at most one request is outstanding.
REQ-010 SHALL accept a request on a cycle with a_valid && a_ready, capture opcode, size, source, address, mask and data, and compute "denied" in that same cycle.
REQ-011 SHALL move from IDLE to WAIT on acceptance, loading a 4-bit counter with LATENCY-1 when LATENCY>0; when LATENCY==0 it SHALL go directly to RESP.
REQ-012 SHALL, in WAIT, decrement the counter each cycle and go to RESP on the cycle the counter equals 0.
REQ-013 SHALL give d_valid = (state==RESP), so d_valid first rises LATENCY+1 cycles after the acceptance edge.
REQ-014 SHALL hold all D fields stable while d_valid && !d_ready.
REQ-015 SHALL go from RESP to IDLE on d_valid && d_ready, with a_ready high on the following cycle; a request SHALL NOT be accepted in the same cycle as the handshake.
REQ-016 SHALL map opcodes as follows:
- Get(4) -> AccessAckData(1)
- PutFullData(0) or PutPartialData(1) -> AccessAck(0)
- Arithmetic(2) or Logical(3) -> AccessAckData(1), denied
- 5, 6, 7 -> AccessAck(0), denied
REQ-017 SHALL deny a request when any of these hold: address < BASE_ADDR; address >= BASE_ADDR + 8*DEPTH_WORDS; a_size > 3; address not aligned to 2^a_size; unsupported opcode.
REQ-018 SHALL, for a non-denied Put, write the addressed word at the acceptance edge, updating only the byte lanes with a_mask bit = 1.
REQ-019 SHALL, for a non-denied Get, register the addressed word at the acceptance edge and present it on d_data unmasked.
REQ-020 SHALL drive d_data = 0 on any denied response and on any AccessAck.
REQ-021 SHALL drive d_corrupt = d_denied && (d_opcode==AccessAckData), and 0 otherwise.
REQ-022 SHALL compute the word index as (a_address - BASE_ADDR) >> 3, using the low log2(DEPTH_WORDS) bits only.
REQ-023 SHALL set err_seen on the acceptance of any denied request and hold it until reset.

Reset
REQ-024 SHALL, while reset is asserted, immediately force: state=IDLE, counter=0, d_valid=0, d_opcode=0, d_size=0, d_source=0, d_denied=0, d_data=0, d_corrupt=0, err_seen=0.
REQ-025 SHALL keep a_ready low while reset is high and raise it on the first clock after deassertion.
REQ-026 SHALL, on reset during WAIT or RESP, discard the outstanding request with no response; any write already performed SHALL remain.
REQ-027 SHALL leave storage contents uninitialized by reset.

Verification
REQ-028 Bench SHALL cover: PutFullData addr 0x8000_0010, mask 0xFF, data 0x1122334455667788, source 0x1A5 -> AccessAck, source 0x1A5, denied 0, d_valid 3 cycles after acceptance; then Get of the same address -> AccessAckData, data 0x1122334455667788.
REQ-029 Bench SHALL cover: PutPartialData mask 0x0F, data 0xAAAAAAAA_BBBBBBBB to the word above, then Get -> 0x11223344_BBBBBBBB.
REQ-030 Bench SHALL cover: Get addr 0x7FFF_FFF8 and Get addr 0x8000_0804 size 3 -> both AccessAckData, denied 1, corrupt 1, data 0, err_seen 1.
REQ-031 Bench SHALL cover: d_ready held low for 5 cycles in RESP -> d_valid and all D fields stable, a_ready 0 throughout; a_ready=1 the cycle after d_ready rises.
REQ-032 Bench SHALL cover: LATENCY=0 build -> d_valid on the cycle after acceptance; back-to-back requests accepted every 2 cycles with d_ready=1.
REQ-033 Bench SHALL cover: reset asserted in WAIT -> d_valid=0 and err_seen=0 immediately, with no stale response after release.
